sd_spi_sequencer: RTL and testbench
===================================

Name: sd_spi_sequencer

Overview:
- Command/transfer sequencer for the SD card SPI path; owns chip-select and drives the byte-level SPI master through its start/busy/new_data handshake.
- Runs the card power-up sequence: dummy clocks, CMD0, CMD8, then CMD55+ACMD41 until ready.
- Executes single-block reads (CMD17) and streams the 512 data bytes to the audio sample buffer.
- Sits between the top-level playback control and the SPI master; nothing else issues SPI traffic to the card.

Parameters:
- INIT_DUMMY_BYTES, 10, 0xFF bytes sent with ss high before CMD0 (80 SCK cycles, at least the required 74).
- NCR_MAX, 8, 0xFF poll bytes allowed while waiting for an R1 response.
- ACMD41_RETRIES, 1000, maximum CMD55+ACMD41 attempts before failure.
- TOKEN_TIMEOUT, 4096, maximum poll bytes allowed while waiting for the 0xFE data token.
- BLOCK_BYTES, 512, data bytes per block.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- init_start, in, 1: one-cycle pulse; begins power-up sequence.
- init_done, out, 1: high while the card is initialised and idle; blocks are readable.
- rd_start, in, 1: one-cycle pulse; begins a block read.
- rd_addr, in, 32: CMD17 argument; captured on rd_start and sent unmodified.
- rd_busy, out, 1: high from the accepted rd_start until the read finishes.
- data_out, out, 8: current block data byte.
- data_valid, out, 1: one-cycle strobe per byte on data_out.
- error, out, 1: sticky failure flag; cleared only by rst or init_start.
- err_code, out, 3: 1=CMD0 R1!=0x01, 2=CMD8 bad echo or illegal, 3=ACMD41 retries exhausted, 4=R1 timeout, 5=token timeout or error token, 6=CMD17 R1!=0x00.
- ss, out, 1: card chip-select, active-low.
- spi_start, out, 1: one-cycle request to the SPI master to send spi_data_in.
- spi_data_in, out, 8: byte to transmit.
- spi_busy, in, 1: SPI master is shifting.
- spi_new_data, in, 1: one-cycle strobe; spi_data_out is valid.
- spi_data_out, in, 8: byte received from the card.

Behaviour:
- Reset values: ss=1, spi_start=0, spi_data_in=0xFF, init_done=0, rd_busy=0, data_valid=0, data_out=0, error=0, err_code=0.
- Reset mid-transfer aborts immediately. A spi_new_data arriving after reset is discarded.
- Byte primitive:
  - Assert spi_start for exactly one cycle, only when spi_busy=0.
  - Then wait for spi_new_data; the received byte is captured in that cycle.
  - Exactly one byte is outstanding at any time.
- Command frame, 6 bytes: {01,cmd[5:0]}, arg[31:24]..arg[7:0], crc.
  - crc=0x95 for CMD0, 0x87 for CMD8, 0x01 for all others.
- R1 wait:
  - Send 0xFF polls until the received byte has bit7=0.
  - More than NCR_MAX polls gives err_code 4.
- After every command or transaction: ss=1, then one 0xFF byte is sent before the next ss=0.
- FSM states: UNINIT, DUMMY, CMD0, CMD8, CMD55, ACMD41, READY, CMD17, TOKEN, DATA, CRC, FAIL.
- UNINIT: on init_start, clear error, go to DUMMY.
- DUMMY: send INIT_DUMMY_BYTES bytes of 0xFF with ss=1, then go to CMD0.
- CMD0: arg 0. R1 must be 0x01, else FAIL(1).
- CMD8: arg 0x000001AA.
  - R1 must be 0x01.
  - Then read 4 more bytes; the last must equal 0xAA, else FAIL(2).
- CMD55: arg 0. R1 must be 0x00 or 0x01.
- ACMD41: arg 0x40000000.
  - R1=0x00: go to READY.
  - R1=0x01: retry from CMD55 (retry counter counts ACMD41 attempts).
  - More than ACMD41_RETRIES attempts gives FAIL(3).
- READY:
  - init_done=1.
  - rd_start captures rd_addr, sets rd_busy=1, goes to CMD17.
  - rd_start in any other state is ignored; so is init_start in any state other than UNINIT/FAIL.
- CMD17: R1 must be 0x00, else FAIL(6).
- TOKEN:
  - Poll until 0xFE is received.
  - Any byte with top 3 bits 000 is an error token: FAIL(5).
  - More than TOKEN_TIMEOUT polls: FAIL(5).
- DATA:
  - Each received byte goes to data_out with data_valid=1 in the cycle after spi_new_data.
  - Exactly BLOCK_BYTES strobes per read.
- CRC: read and discard 2 bytes, deselect, clear rd_busy, return to READY.
- FAIL:
  - ss=1, init_done=0, rd_busy=0, error=1, err_code held.
  - init_start restarts from DUMMY.
- Counters are wide enough for the parameter maxima with no wrap. The retry counter reaches ACMD41_RETRIES exactly, then fails.
- rd_start arriving in the same cycle as the final CRC deselect is ignored, because the state is not yet READY.

Test Plan:
- Card model answers 0x01, 0x01+{00,00,01,AA}, then ACMD41 0x01 twice and 0x00 → 10 dummy bytes with ss=1, CMD0 frame 40 00 00 00 00 95, CMD8 frame 48 00 00 01 AA 87, 3 ACMD41 attempts, init_done=1, error=0.
- Read with rd_addr=0x00000123, model returns token after 3 polls, data bytes i mod 256 → CMD17 frame 51 00 00 01 23 01, 512 data_valid strobes carrying 0x00..0xFF twice, rd_busy drops, init_done stays 1.
- Model never answers CMD0 (always 0xFF) → after 8 polls error=1, err_code=4, ss=1, init_done=0.
- Model answers ACMD41 with 0x01 forever → exactly 1000 attempts, error=1, err_code=3. A following init_start clears error and restarts DUMMY.
- Model sends error token 0x05 after CMD17 → error=1, err_code=5, zero data_valid strobes, rd_busy=0.
- rst asserted at data byte 200 → next cycle all outputs at reset values, FSM in UNINIT. rd_start while UNINIT is ignored; no spi_start is issued.

Source files
------------

// File: rtl/sd_spi_sequencer.sv
// SD card SPI-mode sequencer: power-up (CMD0/CMD8/ACMD41) and CMD17 block reads.
// Owns chip-select and drives a byte-level SPI master one byte at a time.
module sd_spi_sequencer #(
  parameter int INIT_DUMMY_BYTES = 10,
  parameter int NCR_MAX          = 8,
  parameter int ACMD41_RETRIES   = 1000,
  parameter int TOKEN_TIMEOUT    = 4096,
  parameter int BLOCK_BYTES      = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_start,
  output logic        init_done,
  input  logic        rd_start,
  input  logic [31:0] rd_addr,
  output logic        rd_busy,
  output logic [7:0]  data_out,
  output logic        data_valid,
  output logic        error,
  output logic [2:0]  err_code,
  output logic        ss,
  output logic        spi_start,
  output logic [7:0]  spi_data_in,
  input  logic        spi_busy,
  input  logic        spi_new_data,
  input  logic [7:0]  spi_data_out
);

  typedef enum logic [3:0] {
    UNINIT, DUMMY, CMD0, CMD8, CMD55, ACMD41,
    READY, CMD17, TOKEN, DATA, CRC, FAIL
  } state_t;

  typedef enum logic [1:0] {
    PH_GAP, PH_FRAME, PH_POLL, PH_EXTRA
  } phase_t;

  state_t      state;
  phase_t      phase;
  logic        pend;
  logic [15:0] cnt;
  logic [15:0] retry;
  logic [31:0] addr;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [7:0]  crc;
  logic [7:0]  tx;
  logic [7:0]  rx;
  logic [2:0]  fcode;
  logic        is_cmd;
  logic        issuing;
  logic        rx_ev;

  assign rx      = spi_data_out;
  assign rx_ev   = pend && spi_new_data;
  assign is_cmd  = state inside {CMD0, CMD8, CMD55, ACMD41, CMD17};
  assign issuing = is_cmd || (state inside {DUMMY, TOKEN, DATA, CRC});

  always_comb begin
    cmd = 6'd0;
    arg = 32'd0;
    crc = 8'h01;
    case (state)
      CMD0:   crc = 8'h95;
      CMD8:   begin cmd = 6'd8;  arg = 32'h0000_01AA; crc = 8'h87; end
      CMD55:  cmd = 6'd55;
      ACMD41: begin cmd = 6'd41; arg = 32'h4000_0000; end
      CMD17:  begin cmd = 6'd17; arg = addr; end
      default: ;
    endcase
  end

  always_comb begin
    tx = 8'hFF;
    if (is_cmd && phase == PH_FRAME) begin
      case (cnt[2:0])
        3'd0: tx = {2'b01, cmd};
        3'd1: tx = arg[31:24];
        3'd2: tx = arg[23:16];
        3'd3: tx = arg[15:8];
        3'd4: tx = arg[7:0];
        3'd5: tx = crc;
        default: ;
      endcase
    end
  end

  // Failure decode for the byte completing this cycle; 0 means no failure.
  always_comb begin
    fcode = 3'd0;
    if (rx_ev) begin
      if (state == TOKEN) begin
        if (rx != 8'hFE &&
            (rx[7:5] == 3'b000 || cnt == 16'(TOKEN_TIMEOUT - 1)))
          fcode = 3'd5;
      end else if (is_cmd && phase == PH_POLL) begin
        if (rx[7]) begin
          if (cnt == 16'(NCR_MAX - 1)) fcode = 3'd4;
        end else begin
          case (state)
            CMD0:   if (rx != 8'h01) fcode = 3'd1;
            CMD8:   if (rx != 8'h01) fcode = 3'd2;
            CMD55:  if (rx > 8'h01) fcode = 3'd3;
            ACMD41: if (rx > 8'h01 ||
                        (rx == 8'h01 &&
                         retry == 16'(ACMD41_RETRIES - 1)))
                      fcode = 3'd3;
            CMD17:  if (rx != 8'h00) fcode = 3'd6;
            default: ;
          endcase
        end
      end else if (state == CMD8 && phase == PH_EXTRA &&
                   cnt == 16'd3 && rx != 8'hAA) begin
        fcode = 3'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNINIT;
      phase       <= PH_GAP;
      pend        <= 1'b0;
      cnt         <= 16'd0;
      retry       <= 16'd0;
      addr        <= 32'd0;
      ss          <= 1'b1;
      spi_start   <= 1'b0;
      spi_data_in <= 8'hFF;
      init_done   <= 1'b0;
      rd_busy     <= 1'b0;
      data_valid  <= 1'b0;
      data_out    <= 8'h00;
      error       <= 1'b0;
      err_code    <= 3'd0;
    end else begin
      spi_start  <= 1'b0;
      data_valid <= 1'b0;
      if (issuing && !pend && !spi_busy) begin
        spi_start   <= 1'b1;
        spi_data_in <= tx;
        pend        <= 1'b1;
        ss          <= (state == DUMMY) || (is_cmd && phase == PH_GAP);
      end
      if (rx_ev) pend <= 1'b0;
      if (fcode != 3'd0) begin
        state     <= FAIL;
        ss        <= 1'b1;
        init_done <= 1'b0;
        rd_busy   <= 1'b0;
        error     <= 1'b1;
        err_code  <= fcode;
      end else begin
        case (state)
          UNINIT, FAIL: if (init_start) begin
            state    <= DUMMY;
            cnt      <= 16'd0;
            retry    <= 16'd0;
            error    <= 1'b0;
            err_code <= 3'd0;
            ss       <= 1'b1;
          end
          DUMMY: if (rx_ev) begin
            if (cnt == 16'(INIT_DUMMY_BYTES - 1)) begin
              state <= CMD0;
              phase <= PH_FRAME;
              cnt   <= 16'd0;
            end else cnt <= cnt + 16'd1;
          end
          READY: if (rd_start) begin
            addr    <= rd_addr;
            rd_busy <= 1'b1;
            state   <= CMD17;
            phase   <= PH_GAP;
            cnt     <= 16'd0;
          end
          TOKEN: if (rx_ev) begin
            if (rx == 8'hFE) begin
              state <= DATA;
              cnt   <= 16'd0;
            end else cnt <= cnt + 16'd1;
          end
          DATA: if (rx_ev) begin
            data_out   <= rx;
            data_valid <= 1'b1;
            if (cnt == 16'(BLOCK_BYTES - 1)) begin
              state <= CRC;
              cnt   <= 16'd0;
            end else cnt <= cnt + 16'd1;
          end
          CRC: if (rx_ev) begin
            if (cnt == 16'd1) begin
              ss      <= 1'b1;
              rd_busy <= 1'b0;
              state   <= READY;
            end else cnt <= cnt + 16'd1;
          end
          default: if (rx_ev) begin
            case (phase)
              PH_GAP: begin
                phase <= PH_FRAME;
                cnt   <= 16'd0;
              end
              PH_FRAME: begin
                if (cnt == 16'd5) begin
                  phase <= PH_POLL;
                  cnt   <= 16'd0;
                end else cnt <= cnt + 16'd1;
              end
              PH_POLL: begin
                if (rx[7]) cnt <= cnt + 16'd1;
                else begin
                  cnt   <= 16'd0;
                  phase <= PH_GAP;
                  case (state)
                    CMD0:  begin ss <= 1'b1; state <= CMD8; end
                    CMD8:  phase <= PH_EXTRA;
                    CMD55: begin ss <= 1'b1; state <= ACMD41; end
                    ACMD41: begin
                      ss <= 1'b1;
                      if (rx == 8'h00) begin
                        state     <= READY;
                        init_done <= 1'b1;
                      end else begin
                        retry <= retry + 16'd1;
                        state <= CMD55;
                      end
                    end
                    default: state <= TOKEN;
                  endcase
                end
              end
              default: begin
                if (cnt == 16'd3) begin
                  ss    <= 1'b1;
                  state <= CMD55;
                  phase <= PH_GAP;
                  cnt   <= 16'd0;
                end else cnt <= cnt + 16'd1;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_spi_sequencer.sv
// Bench for sd_spi_sequencer: SPI master + SD card model with frame/data scoreboards.
// Expected frames and data bytes are queued by stimulus and popped by monitors.
module tb_sd_spi_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_start = 1'b0;
  logic        rd_start = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic        spi_busy = 1'b0;
  logic        spi_new_data = 1'b0;
  logic [7:0]  spi_data_out = 8'hFF;
  logic        init_done, rd_busy, data_valid, error, ss, spi_start;
  logic [7:0]  data_out, spi_data_in;
  logic [2:0]  err_code;

  sd_spi_sequencer dut (
    .clk(clk), .rst(rst),
    .init_start(init_start), .init_done(init_done),
    .rd_start(rd_start), .rd_addr(rd_addr), .rd_busy(rd_busy),
    .data_out(data_out), .data_valid(data_valid),
    .error(error), .err_code(err_code), .ss(ss),
    .spi_start(spi_start), .spi_data_in(spi_data_in),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data),
    .spi_data_out(spi_data_out)
  );

  always #5 clk = ~clk;

  localparam logic [47:0] F_CMD0 = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8 = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_C55  = 48'h77_0000_0000_01;
  localparam logic [47:0] F_A41  = 48'h69_4000_0000_01;

  int n_chk = 0;
  int n_fail = 0;

  logic [47:0] exp_frame[$];
  logic [7:0]  exp_data[$];
  logic [7:0]  rsp_q[$];

  int n_start = 0, ss1_pre = 0, ss0_cnt = 0, ss1_tot = 0;
  int acmd_cnt = 0, dv_cnt = 0;
  bit seen_ss0 = 0, in_frame = 0;
  bit cmd0_silent = 0, acmd_forever = 0, bad_token = 0;
  int fidx = 0;
  logic [47:0] fbuf = '0;
  logic [7:0]  rxb;

  task automatic check(input string name, input logic [47:0] act,
                       input logic [47:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic frame_done(input logic [47:0] f);
    n_chk++;
    if (exp_frame.size() == 0) begin
      n_fail++;
      $display("FAIL frame_unexpected: got %0h expected none", f);
    end else begin
      logic [47:0] e;
      e = exp_frame.pop_front();
      if (f !== e) begin
        n_fail++;
        $display("FAIL frame: got %0h expected %0h", f, e);
      end
    end
    case (f[47:40])
      8'h40: if (!cmd0_silent) begin
        rsp_q.push_back(8'hFF);
        rsp_q.push_back(8'h01);
      end
      8'h48: begin
        rsp_q.push_back(8'h01); rsp_q.push_back(8'h00);
        rsp_q.push_back(8'h00); rsp_q.push_back(8'h01);
        rsp_q.push_back(8'hAA);
      end
      8'h77: rsp_q.push_back(8'h01);
      8'h69: begin
        acmd_cnt++;
        rsp_q.push_back((acmd_forever || acmd_cnt < 3) ? 8'h01 : 8'h00);
      end
      8'h51: begin
        rsp_q.push_back(8'h00);
        repeat (3) rsp_q.push_back(8'hFF);
        if (bad_token) rsp_q.push_back(8'h05);
        else begin
          rsp_q.push_back(8'hFE);
          for (int i = 0; i < 512; i++) rsp_q.push_back(8'(i));
          rsp_q.push_back(8'hAA);
          rsp_q.push_back(8'hBB);
        end
      end
      default: ;
    endcase
  endtask

  // SPI master + card: one byte completes on the cycle after spi_start.
  initial forever begin
    @(negedge clk);
    spi_busy = 1'b0;
    spi_new_data = 1'b0;
    if (spi_start) begin
      n_start++;
      rxb = 8'hFF;
      if (ss) begin
        ss1_tot++;
        if (!seen_ss0) ss1_pre++;
      end else begin
        seen_ss0 = 1;
        ss0_cnt++;
        if (in_frame) begin
          fbuf = {fbuf[39:0], spi_data_in};
          fidx++;
          if (fidx == 6) begin
            in_frame = 0;
            frame_done(fbuf);
          end
        end else if (spi_data_in[7:6] == 2'b01) begin
          in_frame = 1;
          fbuf = {40'd0, spi_data_in};
          fidx = 1;
        end else if (rsp_q.size() > 0) begin
          rxb = rsp_q.pop_front();
        end
      end
      spi_busy = 1'b1;
      spi_new_data = 1'b1;
      spi_data_out = rxb;
    end
  end

  // Data scoreboard monitor.
  initial forever begin
    @(negedge clk);
    if (data_valid) begin
      dv_cnt++;
      n_chk++;
      if (exp_data.size() == 0) begin
        n_fail++;
        $display("FAIL data_unexpected: got %0h expected none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_data.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL data: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

  task automatic pulse_init();
    @(negedge clk); init_start = 1'b1;
    @(negedge clk); init_start = 1'b0;
  endtask

  task automatic pulse_rd(input logic [31:0] a);
    @(negedge clk); rd_addr = a; rd_start = 1'b1;
    @(negedge clk); rd_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk);
      if (error || (init_done && !rd_busy)) break;
    end
    n_chk++;
    if (i == lim) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles", name, lim);
    end
  endtask

  task automatic check_reset(input string t);
    check({t, "_ss"}, ss, 1);
    check({t, "_spi_start"}, spi_start, 0);
    check({t, "_spi_data_in"}, spi_data_in, 8'hFF);
    check({t, "_init_done"}, init_done, 0);
    check({t, "_rd_busy"}, rd_busy, 0);
    check({t, "_data_valid"}, data_valid, 0);
    check({t, "_data_out"}, data_out, 0);
    check({t, "_error"}, error, 0);
    check({t, "_err_code"}, err_code, 0);
  endtask

  task automatic push_init(input int tries);
    exp_frame.push_back(F_CMD0);
    exp_frame.push_back(F_CMD8);
    repeat (tries) begin
      exp_frame.push_back(F_C55);
      exp_frame.push_back(F_A41);
    end
  endtask

  task automatic push_block();
    for (int i = 0; i < 512; i++) exp_data.push_back(8'(i));
  endtask

  initial begin
    int base, k;
    repeat (3) @(negedge clk);
    check_reset("rst0");
    rst = 1'b0;

    // Power-up: CMD0, CMD8, three ACMD41 attempts.
    acmd_cnt = 0; ss1_pre = 0; seen_ss0 = 0;
    push_init(3);
    pulse_init();
    wait_done("init_wait", 2000);
    check("dummy_bytes", ss1_pre, 10);
    check("acmd41_tries", acmd_cnt, 3);
    check("init_done", init_done, 1);
    check("init_error", error, 0);
    check("init_frames_left", exp_frame.size(), 0);

    // Block read at 0x123.
    push_block();
    exp_frame.push_back({8'h51, 32'h0000_0123, 8'h01});
    base = dv_cnt;
    pulse_rd(32'h0000_0123);
    check("rd_busy_set", rd_busy, 1);
    wait_done("read_wait", 3000);
    check("read_strobes", dv_cnt - base, 512);
    check("read_rd_busy", rd_busy, 0);
    check("read_init_done", init_done, 1);
    check("read_error", error, 0);
    check("read_data_left", exp_data.size(), 0);

    // Error token after CMD17.
    bad_token = 1;
    exp_frame.push_back({8'h51, 32'h0000_0456, 8'h01});
    base = dv_cnt;
    pulse_rd(32'h0000_0456);
    wait_done("tok_wait", 500);
    check("tok_error", error, 1);
    check("tok_err_code", err_code, 5);
    check("tok_strobes", dv_cnt - base, 0);
    check("tok_rd_busy", rd_busy, 0);
    check("tok_ss", ss, 1);
    bad_token = 0;

    // Re-init from FAIL, then reset in the middle of a block.
    acmd_cnt = 0;
    push_init(3);
    pulse_init();
    check("reinit_err_clr", error, 0);
    wait_done("reinit_wait", 2000);
    check("reinit_done", init_done, 1);
    push_block();
    exp_frame.push_back({8'h51, 32'h0000_0200, 8'h01});
    base = dv_cnt;
    pulse_rd(32'h0000_0200);
    for (k = 0; k < 2000; k++) begin
      if (dv_cnt - base >= 200) break;
      @(negedge clk);
    end
    check("rst_reach_200", k < 2000, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    exp_data.delete();
    rsp_q.delete();
    in_frame = 0;
    pulse_rd(32'h0000_0999);
    base = n_start;
    repeat (20) @(negedge clk);
    check("uninit_no_start", n_start - base, 0);
    check("uninit_rd_busy", rd_busy, 0);

    // Card silent on CMD0: R1 timeout after 8 polls.
    cmd0_silent = 1;
    exp_frame.push_back(F_CMD0);
    ss0_cnt = 0;
    pulse_init();
    wait_done("cmd0_wait", 500);
    check("cmd0_error", error, 1);
    check("cmd0_err_code", err_code, 4);
    check("cmd0_ss", ss, 1);
    check("cmd0_init_done", init_done, 0);
    check("cmd0_ss0_bytes", ss0_cnt, 14);
    cmd0_silent = 0;

    // ACMD41 never ready: exactly 1000 attempts.
    acmd_forever = 1;
    acmd_cnt = 0;
    push_init(1000);
    pulse_init();
    wait_done("acmd_wait", 60000);
    check("acmd_error", error, 1);
    check("acmd_err_code", err_code, 3);
    check("acmd_tries", acmd_cnt, 1000);
    check("acmd_frames_left", exp_frame.size(), 0);
    acmd_forever = 0;

    // init_start from FAIL clears error and restarts dummy clocks.
    base = ss1_tot;
    pulse_init();
    check("restart_err_clr", error, 0);
    check("restart_err_code", err_code, 0);
    repeat (6) @(negedge clk);
    check("restart_dummy", ss1_tot > base, 1);
    check("restart_ss", ss, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
